// File: rtl/shift_sched_if.sv
// Requester-side bus of the shift-chain scheduler.
// Two requesters, each with a level request, a parallel word and an ack.
// Handshake: a requester raises reqN with dataN stable and holds both until
// it samples ackN high on a rising edge. It drops reqN on that edge. ackN
// is a one-cycle pulse. If reqN falls before it is granted, the request is
// withdrawn and no ack follows.
interface shift_sched_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             ack0;
    logic             ack1;

    // Requester side
    modport master (
        output req0, data0, req1, data1,
        input  ack0, ack1
    );

    // Scheduler side
    modport slave (
        input  req0, data0, req1, data1,
        output ack0, ack1
    );
endinterface

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler for two requesters sharing a serial
// shift chain of DEPTH stages.
// For each granted word the sequence is: one CLEAR cycle (sr_clr=1), the word
// LSB-first on ser_out, DEPTH zero cycles to push the last bit out of the chain,
// then one DONE cycle that pulses done and the ack of the granted requester.
// Optional feature macro: SHIFT_SCHED_PARITY_EN. When it is defined, one extra
// bit is sent after the word: the even parity (XOR) of the captured word.
// All outputs are registered. clr_n is an asynchronous, active-low reset.
module shift_sched #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               clr_n,
    shift_sched_if.slave       bus,
    output logic               ser_out,
    output logic               sr_clr,
    output logic               busy,
    output logic               gnt_id,
    output logic               done,
    output logic [2:0]         dbg_state
);

`ifdef SHIFT_SCHED_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    // Number of bits sent per transfer (word plus optional parity bit)
    localparam int SW   = WIDTH + PAR;
    localparam int CMAX = ((WIDTH + 1) > DEPTH) ? (WIDTH + 1) : DEPTH;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SH_LAST = CW'(SW - 1);
    localparam logic [CW-1:0] FL_LAST = CW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [SW-1:0]   sh;
    logic [CW-1:0]   cnt;
    logic            last_gnt;

    logic            pick_valid;
    logic            pick_id;
    logic [WIDTH-1:0] pick_data;
    logic [SW-1:0]   pick_word;

    assign dbg_state = state;

    // Arbitration: a lone request wins; on a tie the requester that was not
    // granted last wins.
    always_comb begin
        pick_valid = bus.req0 | bus.req1;
        pick_id    = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick_id = ~last_gnt;
        end else if (bus.req1) begin
            pick_id = 1'b1;
        end
        pick_data = pick_id ? bus.data1 : bus.data0;
`ifdef SHIFT_SCHED_PARITY_EN
        pick_word = {^pick_data, pick_data};
`else
        pick_word = pick_data;
`endif
    end

    // Transfer FSM with registered outputs. Each branch loads the outputs
    // that belong to the state being entered, so they line up with it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            ser_out  <= 1'b0;
            sr_clr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            sr_clr   <= 1'b0;
            done     <= 1'b0;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    ser_out <= 1'b0;
                    if (pick_valid) begin
                        state    <= CLEAR;
                        sh       <= pick_word;
                        gnt_id   <= pick_id;
                        last_gnt <= pick_id;
                        busy     <= 1'b1;
                        sr_clr   <= 1'b1;
                        cnt      <= '0;
                    end
                end
                CLEAR: begin
                    // First data bit goes out in the first SHIFT cycle
                    state   <= SHIFT;
                    ser_out <= sh[0];
                    sh      <= sh >> 1;
                    cnt     <= '0;
                end
                SHIFT: begin
                    if (cnt == SH_LAST) begin
                        state   <= FLUSH;
                        ser_out <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        ser_out <= sh[0];
                        sh      <= sh >> 1;
                        cnt     <= cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    ser_out <= 1'b0;
                    if (cnt == FL_LAST) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        bus.ack0 <= ~gnt_id;
                        bus.ack1 <= gnt_id;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ser_out <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    ser_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: expected per-cycle output vectors are built
// from the requested word and the transfer timing, then compared cycle by cycle.
module tb_shift_sched;

    localparam int W = 8;
    localparam int D = 4;
`ifdef SHIFT_SCHED_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SW = W + PAR;
    localparam int L  = SW + D + 2;

    logic       clk;
    logic       clr_n;
    logic       ser_out;
    logic       sr_clr;
    logic       busy;
    logic       gnt_id;
    logic       done;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    // {busy, sr_clr, ser_out, ack0, ack1, done} per cycle
    logic [5:0] exp_q[$];

    shift_sched_if #(.WIDTH(W)) bus ();

    shift_sched #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .bus       (bus),
        .ser_out   (ser_out),
        .sr_clr    (sr_clr),
        .busy      (busy),
        .gnt_id    (gnt_id),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset held across a clock edge; outputs checked while clr_n is low
    task automatic do_reset();
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
        clr_n     = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out", {9'd0, busy, sr_clr, ser_out, bus.ack0, bus.ack1, done, gnt_id}, 16'd0);
        chk("rst_state", {13'd0, dbg_state}, 16'd0);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    // Build the expected vectors for one transfer of word 'data' to requester 'id'
    task automatic build_exp(input logic id, input logic [W-1:0] data);
        logic [SW:0] word;
        logic        p;
        p = 1'b0;
        for (int i = 0; i < W; i++) p = p ^ data[i];
        word = '0;
        word[W-1:0] = data;
        word[W] = p;
        exp_q.delete();
        for (int c = 1; c <= L; c++) begin
            if (c == 1)
                exp_q.push_back(6'b110000);
            else if (c <= SW + 1)
                exp_q.push_back({2'b10, word[c-2], 3'b000});
            else if (c <= SW + D + 1)
                exp_q.push_back(6'b100000);
            else
                exp_q.push_back({3'b100, ~id, id, 1'b1});
        end
    endtask

    // Called in the cycle before the grant edge; checks every cycle of the
    // transfer and drops the granted request on the ack cycle.
    task automatic xfer(input string name, input logic id, input logic [W-1:0] data);
        logic [5:0] e;
        build_exp(id, data);
        @(posedge clk);
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("%s_c%0d", name, c),
                {10'd0, busy, sr_clr, ser_out, bus.ack0, bus.ack1, done}, {10'd0, e});
            if (c == 1) chk($sformatf("%s_gnt", name), {15'd0, gnt_id}, {15'd0, id});
            if (c == L) begin
                if (id) bus.req1 = 1'b0;
                else    bus.req0 = 1'b0;
            end
        end
    endtask

    // One cycle in IDLE between transfers
    task automatic idle_chk(input string name);
        @(posedge clk);
        @(negedge clk);
        chk(name, {12'd0, busy, dbg_state}, 16'd0);
    endtask

    // Several quiet cycles: no ack, not busy
    task automatic quiet_chk(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_%0d", name, i),
                {10'd0, busy, bus.ack0, bus.ack1, dbg_state}, 16'd0);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;

        // 1: single request from requester 0
        do_reset();
        bus.data0 = 8'hA5;
        bus.req0  = 1'b1;
        xfer("t1", 1'b0, 8'hA5);
        quiet_chk("t1_after", 3);

        // 2: simultaneous requests after reset, requester 0 first
        do_reset();
        bus.data0 = 8'h01;
        bus.data1 = 8'h80;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        xfer("t2a", 1'b0, 8'h01);
        idle_chk("t2_idle");
        xfer("t2b", 1'b1, 8'h80);

        // 3: requester 1 alone, then alternation over 4 tied transfers
        do_reset();
        bus.data1 = 8'h3C;
        bus.req1  = 1'b1;
        xfer("t3a", 1'b1, 8'h3C);
        @(posedge clk);
        #1;
        bus.data0 = 8'hC3;
        bus.data1 = 8'h96;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        xfer("t3b", 1'b0, 8'hC3);
        idle_chk("t3_idle1");
        bus.req0 = 1'b1;
        xfer("t3c", 1'b1, 8'h96);
        idle_chk("t3_idle2");
        bus.req1 = 1'b1;
        xfer("t3d", 1'b0, 8'hC3);
        idle_chk("t3_idle3");
        xfer("t3e", 1'b1, 8'h96);

        // 4: asynchronous reset in the middle of SHIFT
        do_reset();
        bus.data0 = 8'hFF;
        bus.req0  = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        chk("t4_pre", {14'd0, busy, ser_out}, 16'h3);
        #2;
        clr_n = 1'b0;
        #1;
        chk("t4_abort", {10'd0, busy, ser_out, sr_clr, dbg_state}, 16'd0);
        bus.req0 = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        quiet_chk("t4_quiet", 16);
        chk("t4_gnt", {15'd0, gnt_id}, 16'd0);
        bus.data1 = 8'h5A;
        bus.req1  = 1'b1;
        xfer("t4b", 1'b1, 8'h5A);

        // 5: parity-relevant word (parity bit appears only in the parity build)
        do_reset();
        bus.data0 = 8'h07;
        bus.req0  = 1'b1;
        xfer("t5", 1'b0, 8'h07);

        // 6: requester 0 raises and withdraws while requester 1 is served
        idle_chk("t6_idle0");
        bus.data1 = 8'h69;
        bus.req1  = 1'b1;
        fork
            xfer("t6", 1'b1, 8'h69);
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.data0 = 8'hEE;
                bus.req0  = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                bus.req0 = 1'b0;
            end
        join
        quiet_chk("t6_quiet", 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
